serial_addsub_ctrl: RTL and testbench

//   Bit-serial adder/subtractor sequencer. Time-shares one Fulladder cell across WIDTH cycles to produce a WIDTH-bit sum or difference.

---
 rtl/serial_addsub_ctrl_pkg.sv | 22 ++
 rtl/serial_addsub_ctrl_if.sv | 31 +++
 rtl/serial_addsub_ctrl_fa.sv | 13 +
 rtl/serial_addsub_ctrl.sv | 116 +++++++++++
 tb/tb_serial_addsub_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared definitions for the bit-serial adder/subtractor sequencer.
// The optional signed-overflow output is enabled by defining SERIAL_ADDSUB_OVF_EN.
package serial_addsub_ctrl_pkg;

  localparam int ADDSUB_WIDTH = 16;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Operand B as presented to the bit slice: inverted for subtraction (carry-in supplies the +1).
  function automatic logic [ADDSUB_WIDTH-1:0] opb_prep(input logic [ADDSUB_WIDTH-1:0] b,
                                                       input logic sub);
    return b ^ {ADDSUB_WIDTH{sub}};
  endfunction

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// Start/busy/done handshake and operand/result bus of the serial adder/subtractor.
// The ovf signal exists only when SERIAL_ADDSUB_OVF_EN is defined.
interface serial_addsub_ctrl_if
  import serial_addsub_ctrl_pkg::*;
#(
  parameter int WIDTH = ADDSUB_WIDTH
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf;

  modport master (output start, sub, a, b,
                  input  busy, done, result, cout, ovf);
  modport slave  (input  start, sub, a, b,
                  output busy, done, result, cout, ovf);
`else
  modport master (output start, sub, a, b,
                  input  busy, done, result, cout);
  modport slave  (input  start, sub, a, b,
                  output busy, done, result, cout);
`endif

endinterface

// File: rtl/serial_addsub_ctrl_fa.sv
// One-bit full adder; the single bit slice time-shared by the serial sequencer.
module serial_addsub_ctrl_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: one full adder, WIDTH cycles per operation.
// Define SERIAL_ADDSUB_OVF_EN to add the registered signed-overflow output.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start; result/cout hold the last operation
// ST_RUN  | one bit per cycle through the full adder, LSB first
// ST_DONE | single cycle with done=1; start here chains the next op
module serial_addsub_ctrl
  import serial_addsub_ctrl_pkg::*;
#(
  parameter int WIDTH = ADDSUB_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  serial_addsub_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             accept;
  logic             last;
  logic             fa_s;
  logic             fa_co;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf_q;
`endif

  serial_addsub_ctrl_fa u_fulladder (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  assign last = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // opa doubles as the sum shift register: sum bits enter at the MSB as operand bits leave at the LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        opa_q   <= bus.a;
        opb_q   <= bus.b ^ {WIDTH{bus.sub}};
        carry_q <= bus.sub;
        cnt_q   <= '0;
      end else if (state_q == ST_RUN) begin
        opa_q   <= {fa_s, opa_q[WIDTH-1:1]};
        opb_q   <= {1'b0, opb_q[WIDTH-1:1]};
        carry_q <= fa_co;
        cnt_q   <= cnt_q + CW'(1);
        if (last) begin
          result_q <= {fa_s, opa_q[WIDTH-1:1]};
          cout_q   <= fa_co;
`ifdef SERIAL_ADDSUB_OVF_EN
          // carry_q at this point is the carry into the MSB
          ovf_q    <= carry_q ^ fa_co;
`endif
        end
      end
    end
  end

  assign bus.busy   = (state_q == ST_RUN);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl: driver queues expectations, monitor checks on done.
module tb_serial_addsub_ctrl;
  import serial_addsub_ctrl_pkg::*;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    int           cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_err;
  int   n_done;
  int   n_push;
  exp_t sb_q[$];

  serial_addsub_ctrl_if #(.WIDTH(W)) bus ();

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push(input logic [W-1:0] r, input logic c, input logic o, input int at);
    exp_t e;
    e.res = r;
    e.co  = c;
    e.ov  = o;
    e.cyc = at;
    sb_q.push_back(e);
    n_push++;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      n_done++;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: done high with no op outstanding (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", 32'(bus.result), 32'(e.res));
        check("cout", 32'(bus.cout), 32'(e.co));
        check("done_latency", 32'(cyc), 32'(e.cyc));
        check("busy_in_done", 32'(bus.busy), 32'(0));
`ifdef SERIAL_ADDSUB_OVF_EN
        check("ovf", 32'(bus.ovf), 32'(e.ov));
`endif
      end
    end
  end

  // Present start for one accept edge; returns the accept cycle number.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                          input bit do_push, input logic [W-1:0] er, input logic ec,
                          input logic eo, output int acc);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_;
    bus.sub   = ts;
    acc       = cyc + 1;
    if (do_push) push(er, ec, eo, acc + W);
    @(posedge clk);
    #1;
    check("busy_after_accept", 32'(bus.busy), 32'(1));
    bus.start = 1'b0;
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                       input logic [W-1:0] er, input logic ec, input logic eo);
    int acc;
    start_op(ta, tb_, ts, 1'b1, er, ec, eo, acc);
    repeat (W + 2) @(posedge clk);
  endtask

  initial begin
    int acc;
    n_cmp = 0;
    n_err = 0;
    n_done = 0;
    n_push = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.sub = OP_ADD;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_result", 32'(bus.result), 32'(0));
    check("rst_cout", 32'(bus.cout), 32'(0));
    rst = 1'b0;

    do_op(16'h1234, 16'h0FFF, OP_ADD, 16'h2233, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, OP_ADD, 16'h0000, 1'b1, 1'b0);
    do_op(16'h0005, 16'h0007, OP_SUB, 16'hFFFE, 1'b0, 1'b0);
    do_op(16'h8000, 16'h0001, OP_SUB, 16'h7FFF, 1'b1, 1'b1);
    do_op(16'h7FFF, 16'h0001, OP_ADD, 16'h8000, 1'b0, 1'b1);
    do_op(16'h1234, 16'h1234, OP_SUB, 16'h0000, 1'b1, 1'b0);

    // start pulsed mid-run with different operands must be ignored
    start_op(16'h00FF, 16'h0F01, OP_ADD, 1'b1, 16'h1000, 1'b0, 1'b0, acc);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a = 16'hFFFF;
    bus.b = 16'hFFFF;
    bus.sub = OP_SUB;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (W + 2) @(posedge clk);

    // reset in the middle of a run aborts it without a done pulse
    start_op(16'h4321, 16'h1111, OP_ADD, 1'b0, '0, 1'b0, 1'b0, acc);
    repeat (6) @(posedge clk);
    #1;
    check("result_held_in_run", 32'(bus.result), 32'(16'h1000));
    check("busy_mid_run", 32'(bus.busy), 32'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", 32'(bus.busy), 32'(0));
    check("midrst_done", 32'(bus.done), 32'(0));
    check("midrst_result", 32'(bus.result), 32'(0));
    rst = 1'b0;
    repeat (W + 4) @(posedge clk);
    do_op(16'hA5A5, 16'h5A5A, OP_ADD, 16'hFFFF, 1'b0, 1'b0);

    // start held through DONE chains a second op with no idle gap
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a = 16'h8000;
    bus.b = 16'h8000;
    bus.sub = OP_ADD;
    acc = cyc + 1;
    push(16'h0000, 1'b1, 1'b1, acc + W);
    push(16'h8003, 1'b0, 1'b1, acc + W + 1 + W);
    @(posedge clk);
    #1;
    check("b2b_busy_first", 32'(bus.busy), 32'(1));
    bus.a = 16'h0003;
    bus.b = 16'h8000;
    bus.sub = OP_SUB;
    repeat (W + 1) @(posedge clk);
    #1;
    check("b2b_busy_second", 32'(bus.busy), 32'(1));
    check("b2b_done_dropped", 32'(bus.done), 32'(0));
    bus.start = 1'b0;
    repeat (W + 3) @(posedge clk);

    check("scoreboard_drained", 32'(sb_q.size()), 32'(0));
    check("done_pulse_count", 32'(n_done), 32'(n_push));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
